icache: RTL and testbench

Direct-mapped, one-word-per-frame instruction cache between the datapath's instruction fetch port and the memory controller. It answers fetch requests from the datapath (imemREN/imemaddr → ihit/imemload) in the same cycle on a hit. On a miss it issues a single-word read to memory, fills the frame, and then hits on the following cycle. It holds no dirty state; flush only invalidates.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/icache_frames.sv | 34 +++
 rtl/icache.sv | 59 +++++
 tb/tb_icache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and sizing for the instruction cache
package cpu_types_pkg;
  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IDX = $clog2(ICACHE_SETS);
  typedef logic [31:0] word_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
  typedef struct packed {
    logic [29-ICACHE_IDX:0] tag;
    logic [ICACHE_IDX-1:0]  idx;
    logic [1:0]             bytoff;
  } icachef_t;
endpackage

// File: rtl/icache_frames.sv
// icache_frames: valid/tag/data storage with one async read port, one write port and flush-all
module icache_frames import cpu_types_pkg::*; #(
  parameter int SETS = ICACHE_SETS,
  localparam int IDX = $clog2(SETS),
  localparam int TW = 30 - IDX
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush,
  input  logic           we,
  input  logic [IDX-1:0] widx,
  input  logic [TW-1:0]  wtag,
  input  word_t          wdata,
  input  logic [IDX-1:0] ridx,
  output logic           rvalid,
  output logic [TW-1:0]  rtag,
  output word_t          rdata
);
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  word_t           data [SETS];
  // flush beats a coincident fill: the payload lands but stays invalid
  always_ff @(posedge CLK)
    if (RST || flush) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  always_ff @(posedge CLK)
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  assign rvalid = valid[ridx];
  assign rtag = tags[ridx];
  assign rdata = data[ridx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache with single-word miss fill
// ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache import cpu_types_pkg::*; #(
  parameter int SETS = ICACHE_SETS,
  localparam int IDX = $clog2(SETS)
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  input  logic  flush
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);
  icache_state_t state, next;
  logic [29:0] miss_addr;
  logic [29-IDX:0] rtag;
  word_t rdata;
  logic rvalid, we, lookup, start, unused_boff;
  icache_frames #(.SETS(SETS)) frames (
    .CLK, .RST, .flush, .we,
    .widx(miss_addr[IDX-1:0]), .wtag(miss_addr[29:IDX]), .wdata(iload),
    .ridx(imemaddr[IDX+1:2]), .rvalid, .rtag, .rdata
  );
  assign unused_boff = ^imemaddr[1:0];
  assign lookup = imemREN && rvalid && rtag == imemaddr[31:IDX+2];
  assign start = state == IDLE && next == FETCH;
  always_comb begin
    ihit = state == IDLE && lookup;
    imemload = ihit ? rdata : '0;
    iREN = state == FETCH;
    iaddr = iREN ? {miss_addr, 2'b00} : '0;
    we = iREN && !iwait;
    next = state == IDLE ? (imemREN && !lookup ? FETCH : IDLE) : (iwait ? FETCH : IDLE);
  end
  always_ff @(posedge CLK) begin
    state <= RST ? IDLE : next;
    if (start) miss_addr <= imemaddr[31:2];
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK)
    if (RST) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (start && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache against a frame-array reference model
module tb_icache;
  logic CLK, RST, imemREN, iwait, flush;
  logic [31:0] imemaddr, iload, imemload, iaddr;
  logic ihit, iREN;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;

  typedef struct {logic [31:0] addr; int len;} fetch_t;
  fetch_t qf[$];
  logic [31:0] qh[$];
  int checks = 0, errors = 0;
  int nxt_wait = 0, fof_req = 0;
  bit flush_now = 0;
  bit mv[16];
  logic [25:0] mt[16];
  logic [31:0] md[16];
  logic [31:0] mh, mm;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h40 ? 32'h2001_0005 : {a[15:0], ~a[15:0]} ^ (a * 32'h0101_0101);
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] x);
    return &x ? x : x + 32'd1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_cnt();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, mh);
    chk("miss_count", miss_count, mm);
`endif
  endtask

  // memory model: holds iwait for nxt_wait fetch cycles, optionally flushing on the fill cycle
  initial begin
    int cnt = 0, fof_done = 0;
    bit act = 0;
    iwait = 1; iload = 0; flush = 0;
    forever begin
      @(negedge CLK);
      flush = flush_now;
      iload = $urandom;
      if (iREN === 1'b1) begin
        if (!act) begin act = 1; cnt = nxt_wait; end
        if (cnt > 0) begin
          iwait = 1; cnt--;
        end else begin
          iwait = 0; iload = memf(iaddr); act = 0;
          if (fof_req > fof_done) begin flush = 1; fof_done++; end
        end
      end else begin
        act = 0; iwait = 1'($urandom_range(0, 1));
      end
    end
  end

  // monitor: pops expected fills on each fetch and expected data on each ihit
  initial begin
    bit inf = 0, abort = 0;
    int len = 0, elen = 0;
    logic [31:0] faddr = 0;
    fetch_t f;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (inf) abort = 1;
      end else begin
        if (ihit) begin
          if (qh.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ihit: got ihit=1 data %h expected no hit", imemload);
          end else chk("imemload", imemload, qh.pop_front());
        end else chk("imemload_nohit", imemload, 0);
        if (iREN) begin
          if (!inf) begin
            inf = 1; len = 0;
            if (qf.size() == 0) begin
              checks++; errors++; elen = -1; faddr = iaddr;
              $display("FAIL unexpected_fetch: got iaddr %h expected no fetch", iaddr);
            end else begin
              f = qf.pop_front(); faddr = f.addr; elen = f.len;
            end
          end
          chk("iaddr", iaddr, faddr);
          len++;
        end else begin
          if (inf && !abort && elen >= 0) chk("fetch_len", len, elen);
          inf = 0; abort = 0;
          chk("iaddr_idle", iaddr, 0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int w, input bit fof);
    int idx = int'(a[5:2]);
    logic [25:0] tg = a[31:6];
    bit hit = mv[idx] && mt[idx] == tg;
    int lat = 0;
    fetch_t f;
    f.addr = {a[31:2], 2'b00}; f.len = w + 1;
    if (!hit) begin
      qf.push_back(f); mm = sat(mm);
      if (fof) begin qf.push_back(f); mm = sat(mm); fof_req++; end
      mv[idx] = 1; mt[idx] = tg; md[idx] = memf(f.addr);
    end
    qh.push_back(md[idx]); mh = sat(mh);
    nxt_wait = w; imemREN = 1; imemaddr = a;
    forever begin
      @(negedge CLK);
      if (ihit === 1'b1 || lat > 60) break;
      lat++;
    end
    if (lat > 60) begin
      checks++; errors++;
      $display("FAIL ihit_timeout: got no ihit for %h expected ihit within 60 cycles", a);
    end else if (!fof || hit) chk("latency", lat, hit ? 0 : w + 2);
    @(posedge CLK); #1;
    imemREN = 0; imemaddr = $urandom;
  endtask

  task automatic flush_pulse();
    flush_now = 1;
    @(posedge CLK); #1;
    flush_now = 0;
    foreach (mv[i]) mv[i] = 0;
  endtask

  initial begin
    logic [31:0] a;
    fetch_t f;
    RST = 1; imemREN = 0; imemaddr = 0;
    foreach (mv[i]) mv[i] = 0;
    mh = 0; mm = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ihit", ihit, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    check_cnt();
    @(posedge CLK); #1;
    RST = 0;
    issue(32'h40, 3, 0);
    check_cnt();
    issue(32'h80, 1, 0);
    issue(32'h40, 2, 0);
    issue(32'h40, 0, 0);
    issue(32'h44, 2, 1);
    issue(32'h44, 0, 0);
    // request drops right after the miss is taken; fill must still land for 0xC8
    a = 32'hC8; f.addr = a; f.len = 4;
    qf.push_back(f); mm = sat(mm);
    mv[2] = 1; mt[2] = a[31:6]; md[2] = memf(a);
    nxt_wait = 3; imemREN = 1; imemaddr = a;
    @(posedge CLK); #1;
    imemREN = 0; imemaddr = 32'h100;
    repeat (10) @(posedge CLK);
    #1;
    issue(a, 0, 0);
    // reset while the fill is still waiting on memory
    a = 32'h300; f.addr = a; f.len = 6;
    qf.push_back(f); mm = sat(mm);
    nxt_wait = 5; imemREN = 1; imemaddr = a;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1; imemREN = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rstmid_iREN", iREN, 0);
    chk("rstmid_ihit", ihit, 0);
    foreach (mv[i]) mv[i] = 0;
    mh = 0; mm = 0;
    check_cnt();
    @(posedge CLK); #1;
    RST = 0;
    issue(32'h40, 1, 0);
`ifdef ICACHE_STATS_EN
    force_sat: begin
      dut.hit_count = 32'hFFFF_FFFE;
      mh = 32'hFFFF_FFFE;
      repeat (3) issue(32'h40, 0, 0);
      check_cnt();
    end
`endif
    for (int n = 0; n < 250; n++) begin
      int r = $urandom_range(0, 9);
      int ts = $urandom_range(0, 2);
      logic [25:0] tg = ts == 2 ? 26'h3FF_FFFF : 26'(ts);
      logic [3:0] ix = 4'($urandom_range(0, 5));
      logic [1:0] off = 2'($urandom_range(0, 3));
      if (r == 0) flush_pulse();
      else issue({tg, ix, off}, $urandom_range(0, 3), r == 1);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    repeat (5) @(posedge CLK);
    chk("fetch_queue_empty", qf.size(), 0);
    chk("hit_queue_empty", qh.size(), 0);
    check_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
